// File: rtl/arb_pkg.sv
// Shared types and the circular priority pick for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Scan from the farthest distance down so the nearest set bit wins last.
  function automatic pick_t rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [ID_W-1:0]  ptr
  );
    pick_t           p;
    logic [ID_W-1:0] k;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + ID_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dec3to8_onehot.sv
// 3-bit index to 8-bit one-hot decode with enable.
module dec3to8_onehot (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with held grants and registered one-hot gnt.
// Define ARB_TIMEOUT_EN to revoke owners that hold longer than TIMEOUT_CYC.
import arb_pkg::*;

module rr_arbiter8 #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n, id_n, nxt;
  logic             valid_n, drop, revoke, load;
  logic [N_REQ-1:0] gnt_n, masked;
  pick_t            pk;

  assign nxt    = gnt_id + 1'b1;
  assign drop   = !req[gnt_id];
  assign masked = req & ~(N_REQ'(1) << gnt_id);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  assign revoke = (state == GRANT) && req[gnt_id]
                  && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= revoke;
      if (load)
        cnt <= '0;
      else if (state == GRANT)
        cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = gnt_id;
    valid_n = gnt_valid;
    load    = 1'b0;
    pk      = '0;
    unique case (state)
      IDLE: begin
        pk = rr_pick(req, ptr);
        if (pk.found) begin
          id_n    = pk.idx;
          valid_n = 1'b1;
          load    = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (drop || revoke) begin
          // The old owner is masked so a revoke cannot re-win this edge.
          ptr_n = nxt;
          pk    = rr_pick(masked, nxt);
          if (pk.found) begin
            id_n = pk.idx;
            load = 1'b1;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  dec3to8_onehot u_dec (
    .en     (valid_n),
    .idx    (id_n),
    .onehot (gnt_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      gnt       <= gnt_n;
    end
  end

endmodule
